// File: rtl/updown_counter_bank.sv
// Bank of NCH independent up/down counters, each with its own modulo limit, parallel load,
// wrap/saturate boundary handling, a terminal-count pulse and a sticky overflow flag.
module updown_counter_bank #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   sat_mode,
   input  logic [NCH-1:0]         en,
   input  logic [NCH-1:0]         up,
   input  logic [SELW-1:0]        ch_sel,
   input  logic                   load,
   input  logic [WIDTH-1:0]       load_val,
   input  logic                   lim_we,
   input  logic [WIDTH-1:0]       lim_val,
   input  logic [NCH-1:0]         ovf_clr,
   output logic [NCH*WIDTH-1:0]   count,
   output logic [NCH-1:0]         tc_pulse,
   output logic [NCH-1:0]         ovf_sticky
);

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [WIDTH-1:0] r_count;
      logic [WIDTH-1:0] r_limit;
      logic             r_tc;
      logic             r_ovf;
      logic [WIDTH-1:0] w_count_nxt;
      logic [WIDTH-1:0] w_limit_nxt;
      logic [WIDTH-1:0] w_base;
      logic [WIDTH-1:0] w_cap;
      logic             w_sel;
      logic             w_ld;
      logic             w_lw;
      logic             w_event;

      // An out-of-range ch_sel never matches any channel, so writes to it are dropped.
      assign w_sel  = (ch_sel == SELW'(gi));
      assign w_ld   = load & w_sel;
      assign w_lw   = lim_we & w_sel;
      assign w_base = w_ld ? load_val : r_count;
      assign w_cap  = w_lw ? lim_val : r_limit;

      // Compare against the boundary before stepping so the counter can never overflow.
      always_comb begin
         w_count_nxt = r_count;
         w_limit_nxt = w_lw ? lim_val : r_limit;
         w_event     = 1'b0;
         if (clr) begin
            w_count_nxt = '0;
         end else if (w_ld || w_lw) begin
            w_count_nxt = (w_base < w_cap) ? w_base : w_cap;
         end else if (en[gi]) begin
            if (up[gi]) begin
               if (r_count < r_limit) begin
                  w_count_nxt = r_count + WIDTH'(1);
               end else begin
                  w_event     = 1'b1;
                  w_count_nxt = sat_mode ? r_limit : '0;
               end
            end else begin
               if (r_count != '0) begin
                  w_count_nxt = r_count - WIDTH'(1);
               end else begin
                  w_event     = 1'b1;
                  w_count_nxt = sat_mode ? '0 : r_limit;
               end
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_count <= '0;
            r_limit <= '1;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
         end else begin
            r_count <= w_count_nxt;
            r_limit <= w_limit_nxt;
            r_tc    <= w_event;
            r_ovf   <= w_event | (r_ovf & ~ovf_clr[gi]);
         end
      end

      assign count[gi*WIDTH +: WIDTH] = r_count;
      assign tc_pulse[gi]             = r_tc;
      assign ovf_sticky[gi]           = r_ovf;
   end

endmodule
